// File: rtl/sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : sccb_slave_responder
// Brief    : SCCB/I2C target with an oversampled bus front end and an
//            external register-bank interface (address, write strobe, read data).
// Revision : 1.0
// ============================================================================
module sccb_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       xfer_done
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV_ADDR  = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_SUB_ADDR  = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RD_MACK   = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_hist_q;
    logic                   sda_hist_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

    state_t     state_q,     state_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic       rw_q,        rw_d;
    logic       phase_q,     phase_d;
    logic       rd_load_q,   rd_load_d;
    logic       drive_low_q, drive_low_d;
    logic [7:0] reg_addr_q,  reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q,    reg_we_d;
    logic       busy_q,      busy_d;
    logic       xfer_done_q, xfer_done_d;

    logic [7:0] byte_in;
    assign byte_in = {shift_q[6:0], sda_s};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        phase_d     = phase_q;
        rd_load_d   = rd_load_q;
        drive_low_d = drive_low_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        busy_d      = busy_q;
        xfer_done_d = 1'b0;

        if (stop_det) begin
            state_d     = ST_IDLE;
            drive_low_d = 1'b0;
            busy_d      = 1'b0;
            xfer_done_d = busy_q;
            phase_d     = 1'b0;
            rd_load_d   = 1'b0;
        end else if (start_det) begin
            state_d     = ST_DEV_ADDR;
            bit_cnt_d   = 3'd0;
            drive_low_d = 1'b0;
            phase_d     = 1'b0;
            rd_load_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: begin
                    drive_low_d = 1'b0;
                end
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_d = ST_DEV_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_SUB_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_addr_d = byte_in;
                            state_d    = ST_SUB_ACK;
                            phase_d    = 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_wdata_d = byte_in;
                            reg_we_d    = 1'b1;
                            state_d     = ST_WDATA_ACK;
                            phase_d     = 1'b0;
                        end
                    end
                end
                ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    // First falling edge starts the ACK drive, the second ends it.
                    if (scl_fall) begin
                        if (!phase_q) begin
                            drive_low_d = 1'b1;
                            phase_d     = 1'b1;
                        end else begin
                            drive_low_d = 1'b0;
                            phase_d     = 1'b0;
                            bit_cnt_d   = 3'd0;
                            if (state_q == ST_DEV_ACK) begin
                                if (rw_q) begin
                                    state_d     = ST_RDATA;
                                    shift_d     = reg_rdata;
                                    drive_low_d = ~reg_rdata[7];
                                end else begin
                                    state_d = ST_SUB_ADDR;
                                end
                            end else if (state_q == ST_SUB_ACK) begin
                                state_d = ST_WDATA;
                            end else begin
                                state_d    = ST_WDATA;
                                reg_addr_d = reg_addr_q + 8'd1;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (rd_load_q) begin
                            shift_d     = reg_rdata;
                            drive_low_d = ~reg_rdata[7];
                            rd_load_d   = 1'b0;
                        end else begin
                            shift_d     = {shift_q[6:0], 1'b0};
                            drive_low_d = ~shift_q[6];
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RD_MACK;
                            phase_d = 1'b0;
                        end
                    end
                end
                ST_RD_MACK: begin
                    if (scl_fall && !phase_q) begin
                        drive_low_d = 1'b0;
                        phase_d     = 1'b1;
                    end else if (scl_rise && phase_q) begin
                        phase_d = 1'b0;
                        if (!sda_s) begin
                            // Next byte is fetched on the falling edge that ends this slot.
                            reg_addr_d = reg_addr_q + 8'd1;
                            state_d    = ST_RDATA;
                            rd_load_d  = 1'b1;
                            bit_cnt_d  = 3'd0;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    drive_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rw_q        <= 1'b0;
            phase_q     <= 1'b0;
            rd_load_q   <= 1'b0;
            drive_low_q <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            phase_q     <= phase_d;
            rd_load_q   <= rd_load_d;
            drive_low_q <= drive_low_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            busy_q      <= busy_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign I2C_SDAT  = drive_low_q ? 1'b0 : 1'bz;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_we    = reg_we_q;
    assign busy      = busy_q;
    assign xfer_done = xfer_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_slave_responder
// Brief    : Directed bit-banged SCCB master against sccb_slave_responder.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sccb_slave_responder;

    localparam int Q = 40;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl   = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic       busy;
    logic       xfer_done;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int xfer_cnt = 0;
    int stray_low = 0;
    logic [15:0] we_log [$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    sccb_slave_responder #(
        .SLAVE_ADDR  (7'h21),
        .SYNC_STAGES (2)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .I2C_SCLK  (scl),
        .I2C_SDAT  (sda),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt++;
            we_log.push_back({reg_addr, reg_wdata});
        end
        if (xfer_done) xfer_cnt++;
        if (!m_low && sda === 1'b0) stray_low++;
    end

    task automatic bit_x(input logic b, output logic s);
        m_low = ~b; #Q;
        scl = 1'b1; #Q;
        s = sda;    #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic do_start;
        m_low = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b1; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic do_stop;
        m_low = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_low = 1'b0; #Q;
        #(4*Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(d[i], s);
        bit_x(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack, output logic seen);
        logic s;
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(mack, seen);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #53;
        checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", reg_addr); end
        checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h exp 00", reg_wdata); end
        checks++; if ({reg_we, busy, xfer_done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {reg_we, busy, xfer_done}); end
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b exp 1", sda); end
        rst_n = 1'b1;
        #(4*Q);
    endtask

    task automatic test_write_single;
        logic a0, a1, a2;
        int w0, x0;
        logic b_mid;
        w0 = we_log.size(); x0 = xfer_cnt;
        do_start;
        write_byte(8'h42, a0);
        b_mid = busy;
        write_byte(8'h12, a1);
        write_byte(8'h80, a2);
        do_stop;
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL wr_acks got %b exp 000", {a0, a1, a2}); end
        checks++; if (b_mid !== 1'b1) begin errors++; $display("FAIL wr_busy_mid got %b exp 1", b_mid); end
        checks++; if (we_log.size() - w0 != 1) begin errors++; $display("FAIL wr_we_count got %0d exp 1", we_log.size() - w0); end
        else begin
            checks++; if (we_log[w0] !== 16'h1280) begin errors++; $display("FAIL wr_we_data got %h exp 1280", we_log[w0]); end
        end
        checks++; if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL wr_xfer_done got %0d exp 1", xfer_cnt - x0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_read;
        logic a, n, m;
        logic [7:0] d, d2;
        int w0;
        w0 = we_log.size();
        do_start;
        write_byte(8'h42, a);
        write_byte(8'h0A, a);
        do_stop;
        do_start;
        write_byte(8'h43, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b exp 0", a); end
        read_byte(d, 1'b1, n);
        do_stop;
        checks++; if (d !== 8'h76) begin errors++; $display("FAIL rd_data got %h exp 76", d); end
        checks++; if (n !== 1'b1) begin errors++; $display("FAIL rd_nack got %b exp 1", n); end
        checks++; if (reg_addr !== 8'h0A) begin errors++; $display("FAIL rd_addr_after got %h exp 0a", reg_addr); end
        checks++; if (we_log.size() != w0) begin errors++; $display("FAIL rd_no_we got %0d exp %0d", we_log.size(), w0); end
        do_start;
        write_byte(8'h43, a);
        read_byte(d, 1'b0, m);
        read_byte(d2, 1'b1, n);
        do_stop;
        checks++; if ({d, d2} !== 16'h765C) begin errors++; $display("FAIL rd2_data got %h exp 765c", {d, d2}); end
        checks++; if (m !== 1'b0) begin errors++; $display("FAIL rd2_mack got %b exp 0", m); end
        checks++; if (reg_addr !== 8'h0B) begin errors++; $display("FAIL rd2_addr_after got %h exp 0b", reg_addr); end
    endtask

    task automatic test_burst_wrap;
        logic a;
        int w0;
        w0 = we_log.size();
        do_start;
        write_byte(8'h42, a);
        write_byte(8'hFF, a);
        write_byte(8'h11, a);
        write_byte(8'h22, a);
        do_stop;
        checks++; if (we_log.size() - w0 != 2) begin errors++; $display("FAIL burst_we_count got %0d exp 2", we_log.size() - w0); end
        else begin
            checks++; if ({we_log[w0], we_log[w0+1]} !== 32'hFF11_0022) begin errors++; $display("FAIL burst_we_data got %h exp ff110022", {we_log[w0], we_log[w0+1]}); end
        end
        checks++; if (reg_addr !== 8'h01) begin errors++; $display("FAIL burst_addr_after got %h exp 01", reg_addr); end
    endtask

    task automatic test_wrong_addr;
        logic a0, a1, b_mid;
        int w0, x0, s0;
        w0 = we_log.size(); x0 = xfer_cnt; s0 = stray_low;
        do_start;
        write_byte(8'hC0, a0);
        b_mid = busy;
        write_byte(8'h12, a1);
        do_stop;
        checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL wrong_acks got %b exp 11", {a0, a1}); end
        checks++; if (stray_low != s0) begin errors++; $display("FAIL wrong_sda_driven got %0d exp %0d", stray_low, s0); end
        checks++; if (we_log.size() != w0) begin errors++; $display("FAIL wrong_we got %0d exp %0d", we_log.size(), w0); end
        checks++; if ({b_mid, busy} !== 2'b00) begin errors++; $display("FAIL wrong_busy got %b exp 00", {b_mid, busy}); end
        checks++; if (xfer_cnt != x0) begin errors++; $display("FAIL wrong_xfer got %0d exp %0d", xfer_cnt, x0); end
    endtask

    task automatic test_stop_midbyte;
        logic a, s;
        int w0, x0;
        w0 = we_log.size(); x0 = xfer_cnt;
        do_start;
        write_byte(8'h42, a);
        write_byte(8'h12, a);
        bit_x(1'b1, s); bit_x(1'b0, s); bit_x(1'b1, s); bit_x(1'b0, s);
        do_stop;
        checks++; if (we_log.size() != w0) begin errors++; $display("FAIL mid_we got %0d exp %0d", we_log.size(), w0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (xfer_cnt - x0 != 1) begin errors++; $display("FAIL mid_xfer got %0d exp 1", xfer_cnt - x0); end
        w0 = we_log.size();
        do_start;
        write_byte(8'h42, a);
        write_byte(8'h34, a);
        write_byte(8'h56, a);
        do_stop;
        checks++; if (we_log.size() - w0 != 1) begin errors++; $display("FAIL mid_next_count got %0d exp 1", we_log.size() - w0); end
        else begin
            checks++; if (we_log[w0] !== 16'h3456) begin errors++; $display("FAIL mid_next_data got %h exp 3456", we_log[w0]); end
        end
    endtask

    task automatic test_reset_midxfer;
        logic a, s, a1, a2;
        logic [7:0] sub;
        int w0;
        sub = 8'h05;
        do_start;
        write_byte(8'h42, a);
        for (int i = 7; i >= 0; i--) bit_x(sub[i], s);
        m_low = 1'b0;
        #1;
        checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstmid_ack_driven got %b exp 0", sda); end
        rst_n = 1'b0;
        #1;
        checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstmid_sda got %b exp 1", sda); end
        checks++; if ({reg_addr, reg_wdata, reg_we, busy, xfer_done} !== 19'd0) begin errors++; $display("FAIL rstmid_outputs got %h exp 0", {reg_addr, reg_wdata, reg_we, busy, xfer_done}); end
        #20;
        rst_n = 1'b1;
        #(2*Q);
        w0 = we_log.size();
        do_start;
        write_byte(8'h42, a);
        write_byte(8'h05, a1);
        write_byte(8'h3C, a2);
        do_stop;
        checks++; if ({a, a1, a2} !== 3'b000) begin errors++; $display("FAIL rstmid_acks got %b exp 000", {a, a1, a2}); end
        checks++; if (we_log.size() - w0 != 1) begin errors++; $display("FAIL rstmid_we_count got %0d exp 1", we_log.size() - w0); end
        else begin
            checks++; if (we_log[w0] !== 16'h053C) begin errors++; $display("FAIL rstmid_we_data got %h exp 053c", we_log[w0]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0A] = 8'h76;
        mem[8'h0B] = 8'h5C;
        test_reset;
        test_write_single;
        test_read;
        test_burst_wrap;
        test_wrong_addr;
        test_stop_midbyte;
        test_reset_midxfer;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sccb_slave_responder.md
Name: sccb_slave_responder

Overview:
- Synthesizable SCCB/I2C target that answers our SCCB master controller on the same two-wire bus. It models the camera side in the fabric for loopback bring-up and verification, and can also expose an on-chip register bank to an external host.
- Oversamples SCL and SDA on iCLK and decodes START, STOP, device address, sub-address, write data and read data.
- Register storage is external: the block drives address, write data and write strobe, and takes read data in.
- The sub-address persists across STOP, which supports the two-phase SCCB read (write sub-address, STOP, START, read).

Parameters:
- SLAVE_ADDR, 7'h21, 7-bit device address (0x42 write / 0x43 read).
- SYNC_STAGES, 2, synchronizer depth for SCL and SDA (minimum 2).

Ports:
- iCLK  in  1  system clock; must be at least 8x the SCL rate.
- iRST_N  in  1  asynchronous active-low reset.
- I2C_SCLK  in  1  bus clock from the master.
- I2C_SDAT  inout  1  bus data; the block drives only 0, otherwise releases to 1'bz.
- reg_addr  out  8  current sub-address.
- reg_wdata  out  8  assembled write byte.
- reg_we  out  1  one-cycle write strobe.
- reg_rdata  in  8  register content at reg_addr; must be valid within 1 iCLK cycle of a reg_addr change.
- busy  out  1  high while this device is addressed.
- xfer_done  out  1  one-cycle pulse at STOP ending an addressed transaction.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - Outputs: reg_addr=0, reg_wdata=0, reg_we=0, busy=0, xfer_done=0, SDA released.
  - Internal state: state=IDLE, synchronizers=1.
  - Reset mid-transfer releases SDA in the same cycle.
- Sync and edge detect: SCL and SDA each pass through SYNC_STAGES flops plus one history flop. Edges are detected on the synchronized signals.
- START/STOP detection:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and take priority over bit processing.
- Bit timing:
  - Bits are sampled on the SCL rising-edge detect.
  - SDA drive changes only on the SCL falling-edge detect.
  - The bit counter runs 0..7; the 9th bit is the ACK slot.
- State machine:
  - IDLE: on START, go to DEV_ADDR.
  - DEV_ADDR: shift 8 bits MSB first. If bits[7:1]==SLAVE_ADDR, go to DEV_ACK and set busy. Otherwise go to IGNORE. The R/W bit is latched.
  - DEV_ACK: drive SDA=0 from the falling edge after bit 8 to the falling edge after the ACK clock. Then go to SUB_ADDR if W, or RDATA if R.
  - SUB_ADDR: shift 8 bits, load reg_addr, go to SUB_ACK (ACK as above), then WDATA.
  - WDATA:
    - Shift 8 bits.
    - On the iCLK cycle after the 8th rising edge: reg_wdata=byte and reg_we=1 for exactly one cycle, at the current reg_addr.
    - Go to WDATA_ACK (ACK driven).
    - On the falling edge ending the ACK: reg_addr+1 (8-bit wrap 0xFF->0x00), then back to WDATA.
  - RDATA:
    - On the falling edge ending DEV_ACK (or RD_MACK): capture reg_rdata into the shift register.
    - Drive each bit on successive falling edges: 0 -> drive low, 1 -> release.
    - After 8 bits, release SDA and go to RD_MACK.
  - RD_MACK:
    - Sample SDA on the rising edge.
    - 0 (ACK): reg_addr+1, then RDATA.
    - 1 (NACK): go to IGNORE; reg_addr is unchanged.
  - IGNORE: never drive SDA; wait for START (-> DEV_ADDR) or STOP (-> IDLE).
- START in any state (repeated start): go to DEV_ADDR, clear the bit counter, release SDA. Any partial byte is discarded with no reg_we.
- STOP in any state:
  - Go to IDLE, release SDA, busy=0.
  - xfer_done pulses if busy was 1.
  - A partial byte gives no reg_we.
  - reg_addr is retained.
- SDA output: I2C_SDAT = drive_low ? 1'b0 : 1'bz. The block never drives 1.

Test Plan:
- Write 0x42,0x12,0x80 with STOP -> all three ACK slots low (master ACK=0), a single reg_we with reg_addr=0x12 and reg_wdata=0x80, xfer_done one pulse, busy back to 0.
- Write 0x42,0x0A with STOP, then START 0x43; bench memory has 0x0A=0x76 -> master reads I2C_RDATA=0x76, master NACK observed, reg_addr=0x0A afterward.
- Burst write 0x42,0xFF,0x11,0x22 -> reg_we (0xFF,0x11) then (0x00,0x22); wrap verified.
- Address 0x60 write sequence -> SDA never driven low, no reg_we, busy stays 0, master ACK=1.
- STOP injected after 4 bits of a data byte -> no reg_we, state IDLE. Next valid write succeeds.
- iRST_N pulsed low during SUB_ACK -> SDA released immediately, all outputs at reset values. Next 0x42,0x05,0x3C transfer writes 0x3C to 0x05.
